// File: rtl/ps2_rx.sv
// PS/2 keyboard receiver: synchronises the device clock/data lines, deframes and checks
// each 11-bit frame, and queues good scancodes for the core behind a DATA/STATUS register pair.
module ps2_rx #(
   parameter int DATA_W      = 32,
   parameter int SYNC_STAGES = 2,
   parameter int TIMEOUT_CYC = 20000,
   parameter int FIFO_AW     = 2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              PS2_CLK,
   input  logic              PS2_DATA,
   input  logic              sel,
   input  logic              we,
   input  logic              addr,
   input  logic [DATA_W-1:0] data_in,
   output logic [DATA_W-1:0] data_out,
   output logic              rdy
);

   localparam int TO_W  = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
   localparam int DEPTH = 1 << FIFO_AW;

   typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_CHECK} state_t;

   state_t                   r_state, w_state_nxt;
   logic [SYNC_STAGES-1:0]   r_clk_sync, r_dat_sync;
   logic                     r_clk_prev;
   logic [3:0]               r_bitcnt;
   logic [9:0]               r_shift;
   logic [TO_W-1:0]          r_to;
   logic [7:0]               r_mem [DEPTH];
   logic [FIFO_AW-1:0]       r_wr, r_rd;
   logic [FIFO_AW:0]         r_cnt;
   logic                     r_ovf, r_perr, r_ferr;

   logic w_cur_clk, w_dat, w_fall, w_to_hit;
   logic w_start, w_shift_en, w_to_err, w_chk;
   logic w_push, w_pop, w_full, w_ne, w_push_ok, w_clr;
   logic w_stop, w_par_ok, w_ferr_set, w_perr_set, w_ovf_set;
   logic [DATA_W-1:0] w_status;
   logic w_unused_ok;

   assign w_cur_clk = r_clk_sync[SYNC_STAGES-1];
   assign w_dat     = r_dat_sync[SYNC_STAGES-1];
   assign w_fall    = r_clk_prev & ~w_cur_clk;
   assign w_to_hit  = (r_to == TO_W'(TIMEOUT_CYC - 1));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_clk_sync <= '1;
         r_dat_sync <= '1;
         r_clk_prev <= 1'b1;
      end else begin
         r_clk_sync <= {r_clk_sync[SYNC_STAGES-2:0], PS2_CLK};
         r_dat_sync <= {r_dat_sync[SYNC_STAGES-2:0], PS2_DATA};
         r_clk_prev <= w_cur_clk;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_state <= S_IDLE;
      else     r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE:  if (w_fall && !w_dat) w_state_nxt = S_SHIFT;
         S_SHIFT: begin
            if (w_fall && r_bitcnt == 4'd9) w_state_nxt = S_CHECK;
            else if (!w_fall && w_to_hit)   w_state_nxt = S_IDLE;
         end
         S_CHECK: w_state_nxt = S_IDLE;
         default: w_state_nxt = S_IDLE;
      endcase
   end

   always_comb begin
      w_start    = (r_state == S_IDLE) && w_fall && !w_dat;
      w_shift_en = (r_state == S_SHIFT) && w_fall;
      w_to_err   = (r_state == S_SHIFT) && !w_fall && w_to_hit;
      w_chk      = (r_state == S_CHECK);
   end

   // Bits enter at the top, so once the stop bit lands: [9]=stop, [8]=parity, [7:0]=data.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_bitcnt <= '0;
         r_shift  <= '0;
         r_to     <= '0;
      end else begin
         if (w_start)         r_bitcnt <= '0;
         else if (w_shift_en) r_bitcnt <= r_bitcnt + 4'd1;
         if (w_shift_en)      r_shift  <= {w_dat, r_shift[9:1]};
         if (r_state != S_SHIFT || w_fall) r_to <= '0;
         else                              r_to <= r_to + TO_W'(1);
      end
   end

   assign w_stop     = r_shift[9];
   assign w_par_ok   = ^r_shift[8:0];
   assign w_push     = w_chk & w_stop & w_par_ok;
   assign w_ferr_set = w_to_err | (w_chk & ~w_stop);
   assign w_perr_set = w_chk & w_stop & ~w_par_ok;

   assign w_ne      = (r_cnt != '0);
   assign w_full    = (r_cnt == (FIFO_AW+1)'(DEPTH));
   assign w_pop     = sel & ~we & ~addr & w_ne;
   assign w_push_ok = w_push & (~w_full | w_pop);
   assign w_ovf_set = w_push & w_full & ~w_pop;
   assign w_clr     = sel & we & addr;

   always_ff @(posedge clk) begin
      if (w_push_ok) r_mem[r_wr] <= r_shift[7:0];
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_wr  <= '0;
         r_rd  <= '0;
         r_cnt <= '0;
      end else begin
         if (w_push_ok) r_wr <= r_wr + FIFO_AW'(1);
         if (w_pop)     r_rd <= r_rd + FIFO_AW'(1);
         case ({w_push_ok, w_pop})
            2'b10:   r_cnt <= r_cnt + (FIFO_AW+1)'(1);
            2'b01:   r_cnt <= r_cnt - (FIFO_AW+1)'(1);
            default: r_cnt <= r_cnt;
         endcase
      end
   end

   // Sticky flags: a set in the same cycle as a write-1-to-clear wins.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_ovf  <= 1'b0;
         r_perr <= 1'b0;
         r_ferr <= 1'b0;
      end else begin
         r_ovf  <= w_ovf_set  | (r_ovf  & ~(w_clr & data_in[1]));
         r_perr <= w_perr_set | (r_perr & ~(w_clr & data_in[2]));
         r_ferr <= w_ferr_set | (r_ferr & ~(w_clr & data_in[3]));
      end
   end

   always_comb begin
      w_status                 = '0;
      w_status[0]              = w_ne;
      w_status[1]              = r_ovf;
      w_status[2]              = r_perr;
      w_status[3]              = r_ferr;
      w_status[8 +: FIFO_AW+1] = r_cnt;
   end

   always_comb begin
      data_out = '0;
      if (addr)      data_out = w_status;
      else if (w_ne) data_out[7:0] = r_mem[r_rd];
   end

   assign rdy = w_ne;

   assign w_unused_ok = &{1'b0, data_in[DATA_W-1:4], data_in[0]};

endmodule

// File: tb/tb_ps2_rx.sv
// Self-checking bench for ps2_rx: directed scenarios plus randomized frames/reads/clears
// compared against a queue-based model of the peripheral.
module tb_ps2_rx;

   localparam int DATA_W = 32;
   localparam int TO_CYC = 100;
   localparam int HALF   = 8;

   logic              clk = 1'b0;
   logic              rst = 1'b1;
   logic              PS2_CLK = 1'b1;
   logic              PS2_DATA = 1'b1;
   logic              sel = 1'b0;
   logic              we = 1'b0;
   logic              addr = 1'b0;
   logic [DATA_W-1:0] data_in = '0;
   logic [DATA_W-1:0] data_out;
   logic              rdy;

   int n_checks = 0;
   int n_fail   = 0;

   logic [7:0] m_q[$];
   bit m_ovf, m_perr, m_ferr;

   ps2_rx #(.DATA_W(DATA_W), .SYNC_STAGES(2), .TIMEOUT_CYC(TO_CYC), .FIFO_AW(2)) dut (
      .clk(clk), .rst(rst), .PS2_CLK(PS2_CLK), .PS2_DATA(PS2_DATA),
      .sel(sel), .we(we), .addr(addr), .data_in(data_in),
      .data_out(data_out), .rdy(rdy)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] exp_status();
      logic [31:0] s;
      s = 32'(m_q.size()) << 8;
      s[0] = (m_q.size() != 0);
      s[1] = m_ovf;
      s[2] = m_perr;
      s[3] = m_ferr;
      return s;
   endfunction

   function automatic logic [10:0] mk_frame(input logic [7:0] d, input bit bad_par, input bit bad_stop);
      logic p;
      p = ~(^d) ^ bad_par;
      return {~bad_stop, p, d, 1'b0};
   endfunction

   // Model of what one received frame does to the peripheral.
   task automatic model_frame(input logic [7:0] d, input bit bad_par, input bit bad_stop);
      if (bad_stop)            m_ferr = 1;
      else if (bad_par)        m_perr = 1;
      else if (m_q.size() == 4) m_ovf = 1;
      else                     m_q.push_back(d);
   endtask

   task automatic model_reset();
      m_q.delete();
      m_ovf = 0; m_perr = 0; m_ferr = 0;
   endtask

   task automatic ps2_bits(input logic [10:0] fr, input int nbits);
      for (int i = 0; i < nbits; i++) begin
         @(negedge clk); PS2_DATA = fr[i];
         repeat (HALF) @(negedge clk);
         PS2_CLK = 1'b0;
         repeat (HALF) @(negedge clk);
         PS2_CLK = 1'b1;
      end
      repeat (HALF) @(negedge clk);
      PS2_DATA = 1'b1;
      repeat (8) @(negedge clk);
   endtask

   task automatic send(input logic [7:0] d, input bit bad_par, input bit bad_stop);
      ps2_bits(mk_frame(d, bad_par, bad_stop), 11);
      model_frame(d, bad_par, bad_stop);
   endtask

   task automatic rd(input logic a, output logic [31:0] v);
      @(negedge clk); sel = 1'b1; we = 1'b0; addr = a;
      #1 v = data_out;
      @(posedge clk); #1 sel = 1'b0;
   endtask

   task automatic w1c(input logic [31:0] m);
      @(negedge clk); sel = 1'b1; we = 1'b1; addr = 1'b1; data_in = m;
      @(posedge clk); #1 sel = 1'b0; we = 1'b0; data_in = '0;
      if (m[1]) m_ovf = 0;
      if (m[2]) m_perr = 0;
      if (m[3]) m_ferr = 0;
   endtask

   task automatic chk_status(input string tag);
      logic [31:0] v;
      rd(1'b1, v);
      check(tag, v, exp_status());
      check({tag, "_rdy"}, 32'(rdy), 32'(m_q.size() != 0));
   endtask

   task automatic chk_data(input string tag);
      logic [31:0] v, e;
      e = (m_q.size() != 0) ? 32'(m_q.pop_front()) : 32'h0;
      rd(1'b0, v);
      check(tag, v, e);
   endtask

   task automatic do_reset();
      @(negedge clk); rst = 1'b1;
      @(negedge clk); rst = 1'b0;
      model_reset();
   endtask

   initial begin
      logic [31:0] v;
      model_reset();
      repeat (3) @(negedge clk);
      rst = 1'b0;
      #1 check("reset_data", data_out, 32'h0);
      check("reset_rdy", 32'(rdy), 32'h0);
      chk_status("reset_status");

      // 1: good frame, read it back
      send(8'h1C, 0, 0);
      rd(1'b1, v); check("t1_status", v, 32'h101);
      check("t1_rdy", 32'(rdy), 32'h1);
      chk_data("t1_data");
      rd(1'b1, v); check("t1_status_after", v, 32'h000);
      check("t1_rdy_after", 32'(rdy), 32'h0);

      // 2: parity error, cleared by W1C
      send(8'h1C, 1, 0);
      rd(1'b1, v); check("t2_status", v, 32'h004);
      w1c(32'h4);
      rd(1'b1, v); check("t2_cleared", v, 32'h000);

      // 3: overflow
      send(8'h1C, 0, 0); send(8'hF0, 0, 0); send(8'h1C, 0, 0);
      send(8'h32, 0, 0); send(8'h21, 0, 0);
      rd(1'b1, v); check("t3_status", v, 32'h403);
      for (int i = 0; i < 4; i++) chk_data("t3_data");
      rd(1'b0, v); check("t3_empty_read", v, 32'h0);
      w1c(32'h2);

      // 4: timeout on a partial frame
      ps2_bits(mk_frame(8'h05, 0, 0), 4);
      repeat (TO_CYC + 10) @(negedge clk);
      m_ferr = 1;
      rd(1'b1, v); check("t4_status", v, 32'h008);
      send(8'h32, 0, 0);
      rd(1'b1, v); check("t4_status2", v, 32'h109);
      chk_data("t4_data");

      // 5: bad stop bit, then a push coinciding with an OVF clear
      w1c(32'h8);
      send(8'h21, 0, 1);
      rd(1'b1, v); check("t5_status", v, 32'h008);
      w1c(32'h8);
      for (int i = 0; i < 5; i++) send(8'(8'h40 + i), 0, 0);
      chk_data("t5_pop");
      chk_status("t5_pre");
      @(negedge clk); sel = 1'b1; we = 1'b1; addr = 1'b1; data_in = 32'h2;
      ps2_bits(mk_frame(8'h1C, 0, 0), 11);
      sel = 1'b0; we = 1'b0; data_in = '0;
      m_ovf = 0; model_frame(8'h1C, 0, 0);
      rd(1'b1, v); check("t5_w1c_push", v, 32'h401);
      for (int i = 0; i < 4; i++) chk_data("t5_drain");

      // 6: reset mid-frame
      ps2_bits(mk_frame(8'h77, 0, 0), 5);
      do_reset();
      rd(1'b1, v); check("t6_status", v, 32'h000);
      send(8'h21, 0, 0);
      chk_data("t6_data");

      // Randomized traffic against the model
      for (int it = 0; it < 60; it++) begin
         int act;
         act = $urandom_range(0, 9);
         if (act < 5) begin
            send(8'($urandom), ($urandom_range(0, 7) == 0), ($urandom_range(0, 7) == 0));
            chk_status("rnd_status");
         end else if (act < 8) begin
            chk_data("rnd_data");
         end else begin
            w1c(32'($urandom) & 32'hF);
            chk_status("rnd_w1c");
         end
      end
      while (m_q.size() != 0) chk_data("rnd_drain");
      chk_status("final_status");

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
